// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared constants and types for the tank sprite motion controller:
//   - default screen geometry, border width and sprite size
//   - facing-direction encoding
//   - motion FSM state encoding
//   - step_clamp(): one signed move plus clamp, used for both axes
// -----------------------------------------------------------------------------
package tank_pkg;

    localparam int PIXELS_HORIZ = 640;
    localparam int PIXELS_VERT  = 480;
    localparam int EDGE_WIDTH   = 20;
    localparam int SPRITE_W     = 60;
    localparam int SPRITE_H     = 60;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_WAIT_TICK = 3'd0,
        ST_SAMPLE    = 3'd1,
        ST_MOVE_Y    = 3'd2,
        ST_MOVE_X    = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Move pos by step (toward 0 when dec = 1) in 11-bit signed arithmetic so
    // an underflow shows up as a negative value instead of a 10-bit wrap,
    // then clamp the result into [lo, hi].
    function automatic logic [9:0] step_clamp(
        input logic [9:0]  pos,
        input logic        dec,
        input logic [10:0] step,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic signed [10:0] nxt;
        if (dec) begin
            nxt = $signed({1'b0, pos}) - $signed(step);
        end else begin
            nxt = $signed({1'b0, pos}) + $signed(step);
        end
        if (nxt < $signed(lo)) begin
            step_clamp = lo[9:0];
        end else if (nxt > $signed(hi)) begin
            step_clamp = hi[9:0];
        end else begin
            step_clamp = nxt[9:0];
        end
    endfunction

endpackage

// File: rtl/tank_motion_ctrl_button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser followed by a frame-sampled debounce counter.
// The synchronised level is only looked at when sample_en is high (once per
// frame); the debounced level flips after Debounce_Frames consecutive samples
// that disagree with it. Any agreeing sample restarts the count.
// Ports:
//   clk        pixel clock
//   rst        synchronous active-high reset
//   sample_en  one-cycle sample strobe
//   btn_in     raw asynchronous button level
//   level_out  debounced level
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int Debounce_Frames = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_in,
    output logic level_out
);

    localparam logic [3:0] THRESH = 4'(Debounce_Frames);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       level_q, level_d;
    logic [3:0] cnt_q,   cnt_d;

    // Synchroniser shift and debounce counter next-state.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sample_en) begin
            if (sync2_q != level_q) begin
                if ((cnt_q + 4'd1) >= THRESH) begin
                    level_d = sync2_q;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchroniser, counter and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out = level_q;

endmodule

// File: rtl/tank_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tank_motion_ctrl
// Moves a sprite once per frame from four debounced buttons. After each
// Frame_Tick_In the FSM walks SAMPLE -> MOVE_Y -> MOVE_X -> DONE, one cycle
// each, so the position only changes during blanking.
// Ports:
//   Master_Clock_In   pixel clock
//   Reset_In          synchronous active-high reset
//   Frame_Tick_In     one-cycle end-of-active-video pulse
//   Up/Down/Left/Right raw button levels
//   Enable_In         1 = movement allowed, 0 = position frozen
//   X_Pos_Out         sprite left column
//   Y_Pos_Out         sprite top row
//   Dir_Out           facing direction (tank_pkg::dir_e)
//   Moving_Out        last update changed the position
//   Update_Done_Out   one-cycle pulse in the DONE cycle
// -----------------------------------------------------------------------------
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int Pixels_Horiz    = PIXELS_HORIZ,
    parameter int Pixels_Vert     = PIXELS_VERT,
    parameter int EdgeWidth       = EDGE_WIDTH,
    parameter int xWidth          = SPRITE_W,
    parameter int yWidth          = SPRITE_H,
    parameter int Step            = 1,
    parameter int Debounce_Frames = 3
) (
    input  logic       Master_Clock_In,
    input  logic       Reset_In,
    input  logic       Frame_Tick_In,
    input  logic       Up,
    input  logic       Down,
    input  logic       Left,
    input  logic       Right,
    input  logic       Enable_In,
    output logic [9:0] X_Pos_Out,
    output logic [9:0] Y_Pos_Out,
    output logic [1:0] Dir_Out,
    output logic       Moving_Out,
    output logic       Update_Done_Out
);

    localparam logic [10:0] X_MIN  = 11'(EdgeWidth + 1);
    localparam logic [10:0] X_MAX  = 11'(Pixels_Horiz - xWidth - EdgeWidth - 1);
    localparam logic [10:0] Y_MIN  = 11'(EdgeWidth + 1);
    localparam logic [10:0] Y_MAX  = 11'(Pixels_Vert - yWidth - EdgeWidth - 1);
    localparam logic [9:0]  X_INIT = 10'((Pixels_Horiz - xWidth) / 2);
    localparam logic [9:0]  Y_INIT = 10'((Pixels_Vert - yWidth) / 2);
    localparam logic [10:0] STEP_V = 11'(Step);

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [9:0] x_start_q, x_start_d;
    logic [9:0] y_start_q, y_start_d;
    logic [1:0] dir_q, dir_d;
    logic       moving_q, moving_d;
    logic       done_q, done_d;

    logic       sample_en;
    logic       up_db, down_db, left_db, right_db;

    assign sample_en = (state_q == ST_SAMPLE);

    button_debounce #(.Debounce_Frames(Debounce_Frames)) u_db_up (
        .clk(Master_Clock_In), .rst(Reset_In), .sample_en(sample_en),
        .btn_in(Up), .level_out(up_db)
    );
    button_debounce #(.Debounce_Frames(Debounce_Frames)) u_db_down (
        .clk(Master_Clock_In), .rst(Reset_In), .sample_en(sample_en),
        .btn_in(Down), .level_out(down_db)
    );
    button_debounce #(.Debounce_Frames(Debounce_Frames)) u_db_left (
        .clk(Master_Clock_In), .rst(Reset_In), .sample_en(sample_en),
        .btn_in(Left), .level_out(left_db)
    );
    button_debounce #(.Debounce_Frames(Debounce_Frames)) u_db_right (
        .clk(Master_Clock_In), .rst(Reset_In), .sample_en(sample_en),
        .btn_in(Right), .level_out(right_db)
    );

    // FSM next-state and per-state datapath updates.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        x_start_d = x_start_q;
        y_start_d = y_start_q;
        dir_d     = dir_q;
        moving_d  = moving_q;
        done_d    = 1'b0;
        case (state_q)
            ST_WAIT_TICK: begin
                if (Frame_Tick_In) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_SAMPLE: begin
                // Debounced levels update at the end of this cycle; remember
                // where we started so DONE can tell whether we moved.
                x_start_d = x_q;
                y_start_d = y_q;
                state_d   = ST_MOVE_Y;
            end
            ST_MOVE_Y: begin
                if (Enable_In && up_db) begin
                    y_d = step_clamp(y_q, 1'b1, STEP_V, Y_MIN, Y_MAX);
                end else if (Enable_In && down_db) begin
                    y_d = step_clamp(y_q, 1'b0, STEP_V, Y_MIN, Y_MAX);
                end else begin
                    y_d = y_q;
                end
                state_d = ST_MOVE_X;
            end
            ST_MOVE_X: begin
                if (Enable_In && left_db) begin
                    x_d = step_clamp(x_q, 1'b1, STEP_V, X_MIN, X_MAX);
                end else if (Enable_In && right_db) begin
                    x_d = step_clamp(x_q, 1'b0, STEP_V, X_MIN, X_MAX);
                end else begin
                    x_d = x_q;
                end
                // Horizontal press wins the facing direction over vertical.
                if (left_db) begin
                    dir_d = DIR_LEFT;
                end else if (right_db) begin
                    dir_d = DIR_RIGHT;
                end else if (up_db) begin
                    dir_d = DIR_UP;
                end else if (down_db) begin
                    dir_d = DIR_DOWN;
                end else begin
                    dir_d = dir_q;
                end
                // Uses x_d so Moving_Out is valid together with the DONE pulse.
                moving_d = Enable_In && ((x_d != x_start_q) || (y_q != y_start_q));
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_WAIT_TICK;
            end
            default: begin
                state_d = ST_WAIT_TICK;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight update.
    always_ff @(posedge Master_Clock_In) begin
        if (Reset_In) begin
            state_q   <= ST_WAIT_TICK;
            x_q       <= X_INIT;
            y_q       <= Y_INIT;
            x_start_q <= X_INIT;
            y_start_q <= Y_INIT;
            dir_q     <= DIR_UP;
            moving_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_start_q <= x_start_d;
            y_start_q <= y_start_d;
            dir_q     <= dir_d;
            moving_q  <= moving_d;
            done_q    <= done_d;
        end
    end

    assign X_Pos_Out       = x_q;
    assign Y_Pos_Out       = y_q;
    assign Dir_Out         = dir_q;
    assign Moving_Out      = moving_q;
    assign Update_Done_Out = done_q;

endmodule
